// File: rtl/i2c_master_burst.sv
// I2C master running full register transactions: addressed burst write, or pointer write
// followed by a repeated-start burst read. SCL comes from a quarter-period clock divider.
module i2c_master_burst #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned MAX_BYTES = 4,
  parameter int unsigned CW        = $clog2(MAX_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   rw,
  input  logic [6:0]             slave_addr,
  input  logic [7:0]             reg_addr,
  input  logic [CW-1:0]          num_bytes,
  input  logic [8*MAX_BYTES-1:0] wdata,
  output logic [8*MAX_BYTES-1:0] rdata,
  output logic                   busy,
  output logic                   done,
  output logic                   nack_err,
  output logic                   scl_o,
  output logic                   sda_oe,
  input  logic                   sda_i
);
  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [3:0] {
    StIdle, StStart, StAddr, StReg, StRstart, StAddrR, StWrByte, StRdByte, StStop, StDone
  } state_t;

  state_t                 state_q, state_d;
  logic [DW-1:0]          div_q;
  logic [1:0]             qtr_q, qtr_d;
  logic [3:0]             bit_q, bit_d;
  logic [CW-1:0]          byte_q, byte_d, n_q, n_clamp;
  logic                   rw_q, ack_q;
  logic [6:0]             addr_q;
  logic [7:0]             reg_q, shift_q, tx_byte;
  logic [8*MAX_BYTES-1:0] wdata_q;
  logic                   tick, accept, nack_hit, last_byte, scl_d, sda_d;

  assign accept    = (state_q == StIdle) && start;
  assign tick      = busy && (div_q == DW'(CLK_DIV - 1));
  assign last_byte = (byte_q == n_q - CW'(1));
  assign n_clamp   = (num_bytes > CW'(MAX_BYTES)) ? CW'(MAX_BYTES) : num_bytes;

  // Sequencing advances only at quarter boundaries; a bit ends when quarter 3 ticks.
  always_comb begin
    state_d  = state_q;
    qtr_d    = qtr_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    nack_hit = 1'b0;
    case (state_q)
      StIdle: if (start) begin
        state_d = StStart;
        qtr_d   = 2'd0;
      end
      StDone: state_d = StIdle;
      default: if (tick) begin
        qtr_d = qtr_q + 2'd1;
        if (qtr_q == 2'd3) begin
          bit_d = bit_q + 4'd1;
          if (state_q == StStart || state_q == StRstart) begin
            state_d = (state_q == StStart) ? StAddr : StAddrR;
            bit_d   = '0;
          end else if (state_q == StStop) begin
            state_d = StDone;
          end else if (bit_q == 4'd8) begin
            bit_d = '0;
            if (ack_q && state_q != StRdByte) begin
              nack_hit = 1'b1;
              state_d  = StStop;
            end else begin
              case (state_q)
                StAddr:  state_d = StReg;
                StReg:   state_d = (n_q == '0) ? StStop : (rw_q ? StRstart : StWrByte);
                StAddrR: state_d = StRdByte;
                default: begin
                  if (last_byte) state_d = StStop;
                  else           byte_d  = byte_q + CW'(1);
                end
              endcase
            end
          end
        end
      end
    endcase
  end

  always_comb begin
    tx_byte = 8'h00;
    case (state_d)
      StAddr:   tx_byte = {addr_q, 1'b0};
      StReg:    tx_byte = reg_q;
      StAddrR:  tx_byte = {addr_q, 1'b1};
      StWrByte: tx_byte = wdata_q[8*byte_d +: 8];
      default:  ;
    endcase
  end

  // Line levels for the quarter about to begin, so the outputs can be registered.
  always_comb begin
    scl_d = 1'b1;
    sda_d = 1'b0;
    case (state_d)
      StStart:  sda_d = qtr_d[1];
      StRstart: begin
        scl_d = (qtr_d != 2'd0);
        sda_d = qtr_d[1];
      end
      StStop: begin
        scl_d = (qtr_d != 2'd0);
        sda_d = ~qtr_d[1];
      end
      StAddr, StReg, StAddrR, StWrByte: begin
        scl_d = qtr_d[1];
        sda_d = (bit_d != 4'd8) && !tx_byte[3'd7 - bit_d[2:0]];
      end
      StRdByte: begin
        scl_d = qtr_d[1];
        sda_d = (bit_d == 4'd8) && !last_byte;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      div_q    <= '0;
      qtr_q    <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      n_q      <= '0;
      rw_q     <= 1'b0;
      addr_q   <= '0;
      reg_q    <= '0;
      wdata_q  <= '0;
      shift_q  <= '0;
      ack_q    <= 1'b0;
      rdata    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      nack_err <= 1'b0;
      scl_o    <= 1'b1;
      sda_oe   <= 1'b0;
    end else begin
      state_q <= state_d;
      qtr_q   <= qtr_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      scl_o   <= scl_d;
      sda_oe  <= sda_d;
      done    <= 1'b0;
      if (accept) begin
        div_q    <= '0;
        bit_q    <= '0;
        byte_q   <= '0;
        busy     <= 1'b1;
        nack_err <= 1'b0;
        rw_q     <= rw;
        addr_q   <= slave_addr;
        reg_q    <= reg_addr;
        n_q      <= n_clamp;
        wdata_q  <= wdata;
        if (rw) rdata <= '0;
      end else if (busy) begin
        div_q <= tick ? '0 : div_q + DW'(1);
      end
      if (nack_hit) nack_err <= 1'b1;
      if (tick && qtr_q == 2'd2) begin
        ack_q <= sda_i;
        if (state_q == StRdByte && bit_q != 4'd8) shift_q <= {shift_q[6:0], sda_i};
      end
      if (tick && qtr_q == 2'd3 && state_q == StRdByte && bit_q == 4'd7) begin
        rdata[8*byte_q +: 8] <= shift_q;
      end
      if (tick && qtr_q == 2'd3 && state_q == StStop) begin
        done <= 1'b1;
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2c_master_burst.sv
// Bench for i2c_master_burst: clock-sampled I2C slave/bus monitor plus a transaction-level
// model of expected bus events, durations, acks and read data.
module tb_i2c_master_burst;
  localparam int CDIV  = 4;
  localparam int MAXB  = 4;
  localparam int CW    = $clog2(MAXB + 1);
  localparam int EV_S  = 256;
  localparam int EV_SR = 257;
  localparam int EV_P  = 258;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              rw = 1'b0;
  logic [6:0]        slave_addr = '0;
  logic [7:0]        reg_addr = '0;
  logic [CW-1:0]     num_bytes = '0;
  logic [8*MAXB-1:0] wdata = '0;
  logic [8*MAXB-1:0] rdata;
  logic              busy, done, nack_err, scl_o, sda_oe;
  logic              sda_line;

  // Slave/monitor state
  bit          slv_low = 1'b0;
  bit          mon_clear = 1'b0;
  int          nack_at = -1;
  logic [7:0]  slave_rd [8];
  int          ev[$];
  bit          mack[$];

  // Reference model state
  int                exp_ev[$];
  bit                exp_ack[$];
  int                m_bits, m_k;
  bit                m_ab;
  logic [8*MAXB-1:0] rdata_exp = '0;
  int                checks = 0;
  int                failures = 0;

  assign sda_line = !sda_oe && !slv_low;

  i2c_master_burst #(.CLK_DIV(CDIV), .MAX_BYTES(MAXB)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .rw         (rw),
    .slave_addr (slave_addr),
    .reg_addr   (reg_addr),
    .num_bytes  (num_bytes),
    .wdata      (wdata),
    .rdata      (rdata),
    .busy       (busy),
    .done       (done),
    .nack_err   (nack_err),
    .scl_o      (scl_o),
    .sda_oe     (sda_oe),
    .sda_i      (sda_line)
  );

  initial forever #5 clk = ~clk;

  // Slave: ACKs every received byte except the one numbered nack_at (counted from S),
  // returns slave_rd[] after an address byte with R=1, logs all bus events.
  initial begin
    int         bitn, rx_cnt, rd_idx;
    bit         in_xfer, reading, rd_pend, first, m_nack, scl_p, sda_p, scl_s, sda_s;
    logic [7:0] shreg, txb;
    bitn = -1; rx_cnt = 0; rd_idx = 0; in_xfer = 0; reading = 0; rd_pend = 0; first = 0;
    m_nack = 0; scl_p = 1; sda_p = 1; shreg = '0; txb = '0;
    forever begin
      @(negedge clk);
      scl_s = scl_o;
      sda_s = sda_line;
      if (mon_clear) begin
        in_xfer = 0; slv_low = 0; bitn = -1; reading = 0; rd_pend = 0;
      end else if (scl_p && scl_s && sda_p && !sda_s) begin
        ev.push_back(in_xfer ? EV_SR : EV_S);
        if (!in_xfer) rx_cnt = 0;
        in_xfer = 1; bitn = -1; reading = 0; rd_pend = 0; first = 1; rd_idx = 0; slv_low = 0;
      end else if (scl_p && scl_s && !sda_p && sda_s) begin
        ev.push_back(EV_P);
        in_xfer = 0; slv_low = 0; reading = 0;
      end else if (in_xfer && !scl_p && scl_s) begin
        if (bitn >= 0 && bitn < 8) shreg = {shreg[6:0], sda_s};
        else if (bitn == 8 && reading) begin
          mack.push_back(sda_s);
          m_nack = sda_s;
        end
      end else if (in_xfer && scl_p && !scl_s) begin
        if (bitn == 7) begin
          ev.push_back(int'(shreg));
          bitn = 8;
          if (reading) slv_low = 0;
          else begin
            slv_low = (rx_cnt != nack_at);
            rd_pend = first && shreg[0] && slv_low;
            rx_cnt++;
            first = 0;
          end
        end else if (bitn == 8) begin
          bitn = 0;
          if (rd_pend) begin
            reading = 1;
            rd_pend = 0;
          end else if (reading && m_nack) reading = 0;
          if (reading) begin
            txb = slave_rd[rd_idx];
            rd_idx++;
            slv_low = !txb[7];
          end else slv_low = 0;
        end else begin
          bitn++;
          if (reading) slv_low = !txb[7-bitn];
        end
      end
      scl_p = scl_s;
      sda_p = sda_s;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic emit(input int b, input bit tx);
    exp_ev.push_back(b);
    m_bits += 9;
    if (tx) begin
      if (m_k == nack_at) m_ab = 1;
      m_k++;
    end
  endtask

  task automatic run_txn(input bit t_rw, input logic [6:0] a, input logic [7:0] r,
                         input int n_req, input logic [31:0] wd, input int nk,
                         input bit disturb);
    int n_eff, cyc, ev_base, mk_base, pulses, exp_cyc;
    n_eff = (n_req > MAXB) ? MAXB : n_req;
    nack_at = nk;
    exp_ev.delete();
    exp_ack.delete();
    m_bits = 1; m_k = 0; m_ab = 0;
    if (t_rw) rdata_exp = '0;
    exp_ev.push_back(EV_S);
    emit(int'({a, 1'b0}), 1);
    if (!m_ab) emit(int'(r), 1);
    if (!m_ab && n_eff > 0) begin
      if (t_rw) begin
        exp_ev.push_back(EV_SR);
        m_bits++;
        emit(int'({a, 1'b1}), 1);
        if (!m_ab) begin
          for (int i = 0; i < n_eff; i++) begin
            emit(int'(slave_rd[i]), 0);
            rdata_exp[8*i +: 8] = slave_rd[i];
            exp_ack.push_back(i == n_eff - 1);
          end
        end
      end else begin
        for (int i = 0; i < n_eff && !m_ab; i++) emit(int'(wd[8*i +: 8]), 1);
      end
    end
    exp_ev.push_back(EV_P);
    m_bits++;
    exp_cyc = CDIV * 4 * m_bits;

    ev_base = ev.size();
    mk_base = mack.size();
    @(negedge clk);
    rw = t_rw; slave_addr = a; reg_addr = r; num_bytes = CW'(n_req); wdata = wd; start = 1;
    @(posedge clk);
    #1 start = 0;
    check("busy_rise", busy, 1);
    cyc = 0;
    while (!done && cyc < 4000) begin
      @(posedge clk);
      #1 cyc++;
      if (disturb && cyc == 200) begin
        start = 1; rw = !t_rw; slave_addr = ~a; reg_addr = ~r; wdata = ~wd; num_bytes = '0;
      end
      if (disturb && cyc == 201) start = 0;
    end
    check("done_cycles", cyc, exp_cyc);
    check("done_high", done, 1);
    check("busy_fall", busy, 0);
    check("nack_err", nack_err, m_ab);
    check("ev_count", ev.size() - ev_base, exp_ev.size());
    for (int i = 0; i < exp_ev.size() && ev_base + i < ev.size(); i++)
      check($sformatf("ev%0d", i), ev[ev_base+i], exp_ev[i]);
    check("mack_count", mack.size() - mk_base, exp_ack.size());
    for (int i = 0; i < exp_ack.size() && mk_base + i < mack.size(); i++)
      check($sformatf("mack%0d", i), mack[mk_base+i], exp_ack[i]);
    check("rdata", rdata, rdata_exp);
    pulses = int'(done);
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1 if (done) pulses++;
    end
    check("done_once", pulses, 1);
  endtask

  initial begin
    int         cyc;
    bit         trw;
    int         tn, nk;
    for (int j = 0; j < 8; j++) slave_rd[j] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_scl", scl_o, 1);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_nack", nack_err, 0);
    check("rst_rdata", rdata, 0);
    @(negedge clk);
    rst = 1;
    repeat (2) @(negedge clk);

    run_txn(0, 7'h50, 8'h10, 2, 32'h0000_55AA, -1, 0);
    slave_rd[0] = 8'h11; slave_rd[1] = 8'h22; slave_rd[2] = 8'h33; slave_rd[3] = 8'h44;
    run_txn(1, 7'h50, 8'h10, 3, 32'h0, -1, 0);
    run_txn(0, 7'h50, 8'h10, 2, 32'h0000_1234, 0, 0);
    run_txn(1, 7'h50, 8'h10, 0, 32'h0, -1, 0);
    run_txn(0, 7'h3C, 8'hA5, 7, 32'hDEAD_BEEF, -1, 0);
    run_txn(1, 7'h3C, 8'h5A, 7, 32'h0, -1, 0);
    run_txn(0, 7'h21, 8'h42, 3, 32'h00C3_9A17, -1, 1);
    run_txn(1, 7'h21, 8'h42, 2, 32'h0, 2, 0);
    run_txn(0, 7'h21, 8'h42, 4, 32'h0102_0304, 3, 0);

    // Reset while SCL is low inside the first data bit 1 of a write.
    @(negedge clk);
    rw = 0; slave_addr = 7'h50; reg_addr = 8'h10; num_bytes = CW'(3); wdata = 32'h00FF_00FF;
    nack_at = -1; start = 1;
    @(posedge clk);
    #1 start = 0;
    repeat (322) @(posedge clk);
    #1;
    check("pre_rst_scl_low", scl_o, 0);
    check("pre_rst_busy", busy, 1);
    rst = 0;
    #1;
    check("mid_rst_scl", scl_o, 1);
    check("mid_rst_sda_oe", sda_oe, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    @(negedge clk);
    rst = 1;
    mon_clear = 1;
    repeat (3) @(negedge clk);
    mon_clear = 0;
    rdata_exp = '0;
    run_txn(0, 7'h50, 8'h10, 1, 32'h0000_0077, -1, 0);

    for (int t = 0; t < 8; t++) begin
      for (int j = 0; j < 8; j++) slave_rd[j] = 8'($urandom);
      trw = 1'($urandom_range(0, 1));
      tn  = $urandom_range(0, 7);
      nk  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, tn + 2) : -1;
      run_txn(trw, 7'($urandom), 8'($urandom), tn, $urandom, nk, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
